// File: rtl/ip_pkg.sv
// Shared definitions for the inner-product parameter path: write-FSM encodings,
// default widths and the position of the half-select bit in a buffer address.
package ip_pkg;

  localparam int unsigned IP_WL = 32;
  localparam int unsigned IP_AW = 9;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_REQ  = 2'd1,
    W_FILL = 2'd2
  } wstate_e;

  // The half select sits directly above the per-half word address.
  function automatic int unsigned half_sel_bit(input int unsigned aw);
    return aw;
  endfunction

endpackage

// File: rtl/ip_param_fill_fsm.sv
// Write side of the parameter ping-pong: DDR segment request, arbiter handshake,
// per-half word counter and close detection.
module ip_param_fill_fsm
  import ip_pkg::*;
#(
  parameter int unsigned AW = IP_AW
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          ip_proc_i,
  input  logic          ddr_ready_i,
  input  logic [1:0]    full_i,
  input  logic          arb_gnt_i,
  input  logic          ddr_valid_i,
  input  logic          ddr_last_i,
  output logic          rd_ddr_en_o,
  output logic          arb_req_o,
  output logic          accept_o,
  output logic [AW-1:0] wcnt_o,
  output logic          close_o,
  output logic [AW:0]   close_len_o,
  output logic          wr_sel_o
);

  localparam logic [AW-1:0] WCNT_MAX = '1;

  wstate_e       state_q, state_d;
  logic [AW-1:0] wcnt_q, wcnt_d;
  logic          wr_sel_q, wr_sel_d;
  logic          rd_ddr_en_q, rd_ddr_en_d;
  logic          arb_req_q, arb_req_d;
  logic          arb_hold_q, arb_hold_d;

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    wr_sel_d    = wr_sel_q;
    rd_ddr_en_d = 1'b0;
    arb_req_d   = arb_req_q;
    accept_o    = 1'b0;
    close_o     = 1'b0;
    unique case (state_q)
      W_IDLE: begin
        if (ip_proc_i && ddr_ready_i && !full_i[wr_sel_q]) begin
          state_d     = W_REQ;
          rd_ddr_en_d = 1'b1;
          arb_req_d   = 1'b1;
        end
      end
      W_REQ: begin
        if (arb_gnt_i) state_d = W_FILL;
      end
      W_FILL: begin
        if (ddr_valid_i) begin
          accept_o = 1'b1;
          if (wcnt_q == WCNT_MAX || ddr_last_i) begin
            close_o   = 1'b1;
            wcnt_d    = '0;
            wr_sel_d  = ~wr_sel_q;
            arb_req_d = 1'b0;
            state_d   = W_IDLE;
          end else begin
            wcnt_d = wcnt_q + AW'(1);
          end
        end
      end
      default: state_d = W_IDLE;
    endcase
    // Request stays visible for one extra cycle, alongside the closing write.
    arb_hold_d = close_o;
    if (!ip_proc_i) begin
      state_d     = W_IDLE;
      wcnt_d      = '0;
      wr_sel_d    = 1'b0;
      rd_ddr_en_d = 1'b0;
      arb_req_d   = 1'b0;
      arb_hold_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= W_IDLE;
      wcnt_q      <= '0;
      wr_sel_q    <= 1'b0;
      rd_ddr_en_q <= 1'b0;
      arb_req_q   <= 1'b0;
      arb_hold_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      wr_sel_q    <= wr_sel_d;
      rd_ddr_en_q <= rd_ddr_en_d;
      arb_req_q   <= arb_req_d;
      arb_hold_q  <= arb_hold_d;
    end
  end

  assign rd_ddr_en_o = rd_ddr_en_q;
  assign arb_req_o   = (arb_req_q || arb_hold_q) && ip_proc_i;
  assign wcnt_o      = wcnt_q;
  assign close_len_o = {1'b0, wcnt_q} + {{AW{1'b0}}, 1'b1};
  assign wr_sel_o    = wr_sel_q;

endmodule

// File: rtl/ip_param_pingpong.sv
// Ping-pong parameter buffer manager: fills two BRAM halves from DDR, tracks
// full flags and valid lengths, and generates drain read addresses.
module ip_param_pingpong
  import ip_pkg::*;
#(
  parameter int unsigned WL = IP_WL,
  parameter int unsigned AW = IP_AW
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          ip_proc_i,
  input  logic          ddr_ready_i,
  output logic          rd_ddr_en_o,
  output logic          arb_req_o,
  input  logic          arb_gnt_i,
  input  logic          ddr_valid_i,
  input  logic [WL-1:0] ddr_data_i,
  input  logic          ddr_last_i,
  output logic          buf_we_o,
  output logic [AW:0]   buf_waddr_o,
  output logic [WL-1:0] buf_wdata_o,
  input  logic          rd_en_i,
  output logic [AW:0]   buf_raddr_o,
  output logic [1:0]    param_buf_full_o,
  output logic          wr_buf_done_o,
  output logic          rd_buf_done_o
);

  localparam int unsigned  HSB   = half_sel_bit(AW);
  localparam logic [AW:0]  LEN_1 = {{AW{1'b0}}, 1'b1};

  logic          accept;
  logic [AW-1:0] wcnt;
  logic          close;
  logic [AW:0]   close_len;
  logic          wr_sel;

  logic          buf_we_q, buf_we_d;
  logic [AW:0]   buf_waddr_q, buf_waddr_d;
  logic [WL-1:0] buf_wdata_q, buf_wdata_d;
  logic [1:0]    full_q, full_d;
  logic [1:0][AW:0] len_q, len_d;
  logic          rd_sel_q, rd_sel_d;
  logic [AW-1:0] rcnt_q, rcnt_d;
  logic          wr_done_q, wr_done_d;
  logic          rd_done_q, rd_done_d;
  logic          rd_fire, rd_last;

  ip_param_fill_fsm #(
    .AW(AW)
  ) u_fill (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .ip_proc_i   (ip_proc_i),
    .ddr_ready_i (ddr_ready_i),
    .full_i      (full_q),
    .arb_gnt_i   (arb_gnt_i),
    .ddr_valid_i (ddr_valid_i),
    .ddr_last_i  (ddr_last_i),
    .rd_ddr_en_o (rd_ddr_en_o),
    .arb_req_o   (arb_req_o),
    .accept_o    (accept),
    .wcnt_o      (wcnt),
    .close_o     (close),
    .close_len_o (close_len),
    .wr_sel_o    (wr_sel)
  );

  assign rd_fire = rd_en_i && full_q[rd_sel_q];
  assign rd_last = rd_fire && ({1'b0, rcnt_q} == len_q[rd_sel_q] - LEN_1);

  always_comb begin
    buf_we_d    = accept;
    buf_waddr_d = buf_waddr_q;
    buf_wdata_d = buf_wdata_q;
    full_d      = full_q;
    len_d       = len_q;
    rd_sel_d    = rd_sel_q;
    rcnt_d      = rcnt_q;
    wr_done_d   = close;
    rd_done_d   = rd_last;
    if (accept) begin
      buf_waddr_d          = '0;
      buf_waddr_d[HSB]     = wr_sel;
      buf_waddr_d[AW-1:0]  = wcnt;
      buf_wdata_d          = ddr_data_i;
    end
    if (close) begin
      full_d[wr_sel] = 1'b1;
      len_d[wr_sel]  = close_len;
    end
    // A half being written is never full, so set and clear never collide.
    if (rd_fire) begin
      if (rd_last) begin
        full_d[rd_sel_q] = 1'b0;
        rd_sel_d         = ~rd_sel_q;
        rcnt_d           = '0;
      end else begin
        rcnt_d = rcnt_q + AW'(1);
      end
    end
    if (!ip_proc_i) begin
      buf_we_d    = 1'b0;
      buf_waddr_d = '0;
      buf_wdata_d = '0;
      full_d      = '0;
      len_d       = '0;
      rd_sel_d    = 1'b0;
      rcnt_d      = '0;
      wr_done_d   = 1'b0;
      rd_done_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      buf_we_q    <= 1'b0;
      buf_waddr_q <= '0;
      buf_wdata_q <= '0;
      full_q      <= '0;
      len_q       <= '0;
      rd_sel_q    <= 1'b0;
      rcnt_q      <= '0;
      wr_done_q   <= 1'b0;
      rd_done_q   <= 1'b0;
    end else begin
      buf_we_q    <= buf_we_d;
      buf_waddr_q <= buf_waddr_d;
      buf_wdata_q <= buf_wdata_d;
      full_q      <= full_d;
      len_q       <= len_d;
      rd_sel_q    <= rd_sel_d;
      rcnt_q      <= rcnt_d;
      wr_done_q   <= wr_done_d;
      rd_done_q   <= rd_done_d;
    end
  end

  assign buf_we_o         = buf_we_q;
  assign buf_waddr_o      = buf_waddr_q;
  assign buf_wdata_o      = buf_wdata_q;
  assign buf_raddr_o      = {rd_sel_q, rcnt_q};
  assign param_buf_full_o = full_q;
  assign wr_buf_done_o    = wr_done_q;
  assign rd_buf_done_o    = rd_done_q;

endmodule

// File: tb/tb_ip_param_pingpong.sv
// Directed bench for ip_param_pingpong with 8-word halves.
module tb_ip_param_pingpong;

  localparam int unsigned WL = 32;
  localparam int unsigned AW = 3;

  logic          clk = 1'b0;
  logic          rstn, ip_proc, ddr_ready, arb_gnt, ddr_valid, ddr_last, rd_en;
  logic [WL-1:0] ddr_data;
  logic          rd_ddr_en, arb_req, buf_we, wr_done, rd_done;
  logic [AW:0]   buf_waddr, buf_raddr;
  logic [WL-1:0] buf_wdata;
  logic [1:0]    full;

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  ip_param_pingpong #(
    .WL(WL),
    .AW(AW)
  ) dut (
    .clk_i            (clk),
    .rstn_i           (rstn),
    .ip_proc_i        (ip_proc),
    .ddr_ready_i      (ddr_ready),
    .rd_ddr_en_o      (rd_ddr_en),
    .arb_req_o        (arb_req),
    .arb_gnt_i        (arb_gnt),
    .ddr_valid_i      (ddr_valid),
    .ddr_data_i       (ddr_data),
    .ddr_last_i       (ddr_last),
    .buf_we_o         (buf_we),
    .buf_waddr_o      (buf_waddr),
    .buf_wdata_o      (buf_wdata),
    .rd_en_i          (rd_en),
    .buf_raddr_o      (buf_raddr),
    .param_buf_full_o (full),
    .wr_buf_done_o    (wr_done),
    .rd_buf_done_o    (rd_done)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_ddr_en"}, rd_ddr_en, 0);
    chk({tag, "_arb_req"},   arb_req,   0);
    chk({tag, "_we"},        buf_we,    0);
    chk({tag, "_waddr"},     buf_waddr, 0);
    chk({tag, "_wdata"},     buf_wdata, 0);
    chk({tag, "_raddr"},     buf_raddr, 0);
    chk({tag, "_full"},      full,      0);
    chk({tag, "_wdone"},     wr_done,   0);
    chk({tag, "_rdone"},     rd_done,   0);
  endtask

  task automatic request();
    step();
    chk("req_rd_ddr_en", rd_ddr_en, 1);
    chk("req_arb_req", arb_req, 1);
    step();
    chk("req_rd_ddr_en_pulse", rd_ddr_en, 0);
  endtask

  task automatic fill(input int half, input int n, input bit last_end, input int dbase);
    for (int i = 0; i < n; i++) begin
      ddr_valid = 1'b1;
      ddr_data  = WL'(dbase + i);
      ddr_last  = last_end && (i == n - 1);
      step();
      chk("fill_we", buf_we, 1);
      chk("fill_waddr", buf_waddr, half * 8 + i);
      chk("fill_wdata", buf_wdata, dbase + i);
      chk("fill_arb_req", arb_req, 1);
      chk("fill_wdone", wr_done, (i == n - 1) && (last_end || n == 8));
    end
    ddr_valid = 1'b0;
    ddr_last  = 1'b0;
  endtask

  task automatic drain(input int half, input int n);
    for (int i = 0; i < n; i++) begin
      rd_en = 1'b1;
      #1;
      chk("drain_raddr", buf_raddr, half * 8 + i);
      step();
      chk("drain_rdone", rd_done, i == n - 1);
    end
    rd_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; ip_proc = 1'b0; ddr_ready = 1'b0; arb_gnt = 1'b0;
    ddr_valid = 1'b0; ddr_last = 1'b0; rd_en = 1'b0; ddr_data = '0;
    #3;
    chk_all_zero("reset");
    step(); step();
    rstn = 1'b1; ip_proc = 1'b1; ddr_ready = 1'b1; arb_gnt = 1'b1;

    // Fill both halves
    request();
    fill(0, 8, 1'b0, 'h100);
    chk("full_01", full, 2'b01);
    request();
    fill(1, 8, 1'b0, 'h200);
    chk("full_11", full, 2'b11);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("no_req_when_full", rd_ddr_en, 0);
    end
    chk("arb_req_dropped", arb_req, 0);

    // Drain half 0, refill it with a short segment
    drain(0, 8);
    chk("full_10", full, 2'b10);
    request();
    fill(0, 5, 1'b1, 'h300);
    chk("full_11_short", full, 2'b11);
    drain(1, 8);
    chk("full_01_after_drain1", full, 2'b01);
    request();

    // Fill-close of half 1 coincides with drain-close of the 5-word half 0
    for (int i = 0; i < 8; i++) begin
      ddr_valid = 1'b1;
      ddr_data  = WL'('h400 + i);
      rd_en     = (i >= 3);
      #1;
      if (i >= 3) chk("sim_raddr", buf_raddr, i - 3);
      step();
      chk("sim_waddr", buf_waddr, 8 + i);
      chk("sim_full", full, (i == 7) ? 2'b10 : 2'b01);
      chk("sim_wdone", wr_done, i == 7);
      chk("sim_rdone", rd_done, i == 7);
    end
    ddr_valid = 1'b0;
    rd_en     = 1'b0;

    // Flush on word 4 of a fill
    request();
    fill(0, 4, 1'b0, 'h500);
    chk("pre_flush_raddr", buf_raddr, 8);
    ddr_valid = 1'b1;
    ddr_data  = WL'('h504);
    ip_proc   = 1'b0;
    #1;
    chk("flush_arb_req_now", arb_req, 0);
    step();
    chk_all_zero("flush");
    ddr_valid = 1'b0;

    // Grant withheld, with an ignored read strobe while nothing is full
    arb_gnt = 1'b0;
    ip_proc = 1'b1;
    rd_en   = 1'b1;
    step();
    chk("gw_rd_ddr_en", rd_ddr_en, 1);
    chk("ign_raddr", buf_raddr, 0);
    chk("ign_rdone", rd_done, 0);
    chk("ign_full", full, 0);
    rd_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ddr_valid = i[0];
      ddr_data  = WL'('h700 + i);
      step();
      chk("gw_we", buf_we, 0);
      chk("gw_arb_req", arb_req, 1);
    end
    ddr_valid = 1'b0;
    arb_gnt   = 1'b1;
    step();
    chk("gw_grant_we", buf_we, 0);
    fill(0, 3, 1'b1, 'h600);
    chk("gw_full", full, 2'b01);

    // Asynchronous reset in the middle of a read
    rd_en = 1'b1;
    #1;
    chk("rst_raddr0", buf_raddr, 0);
    step();
    chk("rst_raddr1", buf_raddr, 1);
    chk("rst_arb_req_pre", arb_req, 1);
    #2;
    rstn = 1'b0;
    #1;
    chk_all_zero("async_rst");
    rd_en = 1'b0;
    #20;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
